divider_result_collector: RTL

- Sits directly downstream of the last divider_cell stage of the pipelined restoring divider.
- Captures each completed result (quotient, remainder, divisor, dividend tag) into a small FIFO and presents it on a valid/ready output interface.
- The divider pipeline cannot stall, so the block also gives upstream launch control a credit signal. Upstream may only start a division when a FIFO slot is guaranteed.
- Flags divide-by-zero results and protocol overflow.

---
 rtl/divider_result_collector.sv | 95 +++++++++
 1 files changed

// File: rtl/divider_result_collector.sv
// Result FIFO behind the last restoring-divider stage. It hands launch credits
// upstream and flags divide-by-zero entries and protocol errors.
module divider_result_collector #(
   parameter int N     = 5,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          launch,
   output logic          can_launch,
   input  logic          in_rdy,
   input  logic [N-1:0]  in_merchant,
   input  logic [N-1:0]  in_remainder,
   input  logic [N-1:0]  in_divisor,
   input  logic [N-1:0]  in_dividend,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_merchant,
   output logic [N-1:0]  out_remainder,
   output logic [N-1:0]  out_dividend,
   output logic          out_div0,
   output logic [AW:0]   count,
   output logic          overflow
);

   typedef struct packed {
      logic [N-1:0] merchant;
      logic [N-1:0] remainder;
      logic [N-1:0] dividend;
      logic         div0;
   } entry_t;

   localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
   localparam logic [AW+1:0] CREDIT_MAX = (AW+2)'(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     inflight;
   logic [AW+1:0]   used;
   logic            pop;
   logic            push;
   logic            launch_err;
   logic            rdy_err;

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   // A full FIFO can still take a result when the head leaves in the same cycle.
   assign push      = in_rdy & ((count != FULL) | pop);

   // Credits count results already stored plus those still inside the pipeline.
   assign used       = {1'b0, count} + {1'b0, inflight};
   assign can_launch = (used < CREDIT_MAX);

   assign launch_err = launch & ~can_launch;
   assign rdy_err    = in_rdy & ((inflight == '0) | ~push);

   assign out_merchant  = mem[rd_ptr].merchant;
   assign out_remainder = mem[rd_ptr].remainder;
   assign out_dividend  = mem[rd_ptr].dividend;
   assign out_div0      = mem[rd_ptr].div0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: storage sits in the reset branch so the head reads back as zero
         // after reset; this keeps it as flops, which is fine at this depth.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         inflight <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{merchant:  in_merchant,
                             remainder: in_remainder,
                             dividend:  in_dividend,
                             div0:      (in_divisor == '0)};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;

         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;

         // A launch and an arrival in the same cycle cancel out.
         if (launch && !in_rdy && inflight != FULL)   inflight <= inflight + 1'b1;
         else if (!launch && in_rdy && inflight != '0) inflight <= inflight - 1'b1;

         if (launch_err || rdy_err) overflow <= 1'b1;
      end
   end

endmodule
